// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the NES bus initiators and the PPU register responder.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] PPU_CTRL   = 16'h2000;
    localparam logic [15:0] PPU_MASK   = 16'h2001;
    localparam logic [15:0] PPU_STATUS = 16'h2002;
    localparam logic [15:0] OAM_ADDR   = 16'h2003;
    localparam logic [15:0] OAM_DATA   = 16'h2004;
    localparam logic [15:0] PPU_SCROLL = 16'h2005;
    localparam logic [15:0] PPU_ADDR   = 16'h2006;
    localparam logic [15:0] PPU_DATA   = 16'h2007;
    localparam logic [15:0] OAM_DMA    = 16'h4014;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA ($4014): halts the CPU and copies one 256-byte page into PPU OAMDATA.
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs_n,
    input  logic        i_rw,
    input  logic [7:0]  i_data,
    output logic        o_rdy,
    output logic        o_bus_en,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data,
    input  logic [7:0]  i_bus_data,
    output logic        o_busy,
    output logic [7:0]  o_debug_index,
    output logic [7:0]  o_debug_page
);

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] byte_latch;
    logic       parity;

    // Registered outputs are loaded alongside each state transition so they
    // always reflect the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            page       <= '0;
            index      <= '0;
            byte_latch <= '0;
            parity     <= 1'b0;
            o_rdy      <= 1'b1;
            o_bus_en   <= 1'b0;
            o_rw       <= RW_READ;
            o_busy     <= 1'b0;
        end else begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (!i_cs_n && i_rw == RW_WRITE) begin
                        page   <= i_data;
                        index  <= '0;
                        state  <= HALT;
                        o_rdy  <= 1'b0;
                        o_busy <= 1'b1;
                    end
                end
                HALT: begin
                    // CPU write cycles ignore RDY, so wait them out here.
                    if (i_rw == RW_READ) begin
                        if (parity) begin
                            state    <= READ;
                            o_bus_en <= 1'b1;
                            o_rw     <= RW_READ;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    state    <= READ;
                    o_bus_en <= 1'b1;
                    o_rw     <= RW_READ;
                end
                READ: begin
                    byte_latch <= i_bus_data;
                    state      <= WRITE;
                    o_rw       <= RW_WRITE;
                end
                WRITE: begin
                    o_rw <= RW_READ;
                    if (index == 8'hFF) begin
                        state    <= IDLE;
                        o_rdy    <= 1'b1;
                        o_busy   <= 1'b0;
                        o_bus_en <= 1'b0;
                    end else begin
                        index <= index + 8'd1;
                        state <= READ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    o_rdy    <= 1'b1;
                    o_busy   <= 1'b0;
                    o_bus_en <= 1'b0;
                    o_rw     <= RW_READ;
                end
            endcase
        end
    end

    always_comb begin
        o_address = '0;
        o_data    = '0;
        if (state == READ) begin
            o_address = {page, index};
        end else if (state == WRITE) begin
            o_address = OAM_DATA_ADDR;
            o_data    = byte_latch;
        end
    end

    assign o_debug_index = index;
    assign o_debug_page  = page;

endmodule

// File: tb/tb_oam_dma.sv
// Directed-plus-random bench for oam_dma against a transfer-level memory model.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_cs_n;
    logic        i_rw;
    logic [7:0]  i_data;
    logic        o_rdy;
    logic        o_bus_en;
    logic [15:0] o_address;
    logic        o_rw;
    logic [7:0]  o_data;
    logic [7:0]  i_bus_data;
    logic        o_busy;
    logic [7:0]  o_debug_index;
    logic [7:0]  o_debug_page;

    oam_dma #(.OAM_DATA_ADDR(16'h2004)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_cs_n       (i_cs_n),
        .i_rw         (i_rw),
        .i_data       (i_data),
        .o_rdy        (o_rdy),
        .o_bus_en     (o_bus_en),
        .o_address    (o_address),
        .o_rw         (o_rw),
        .o_data       (o_data),
        .i_bus_data   (i_bus_data),
        .o_busy       (o_busy),
        .o_debug_index(o_debug_index),
        .o_debug_page (o_debug_page)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    assign i_bus_data = mem[o_address];

    int vectors = 0;
    int miscompares = 0;

    // Cycle number since the last reset edge; its LSB is the get/put parity.
    int unsigned cyc;
    always @(posedge clk) begin
        if (i_reset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    logic [15:0] rd_addr [$];
    int unsigned rd_cyc  [$];
    logic [15:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    int unsigned wr_cyc  [$];
    int          rdy_low;

    always @(negedge clk) begin
        if (!o_rdy) rdy_low <= rdy_low + 1;
        if (o_bus_en && o_rw) begin
            rd_addr.push_back(o_address);
            rd_cyc.push_back(cyc);
        end else if (o_bus_en && !o_rw) begin
            wr_addr.push_back(o_address);
            wr_data.push_back(o_data);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_page(input logic [7:0] pg, input bit pattern);
        for (int i = 0; i < 256; i++)
            mem[{pg, i[7:0]}] = pattern ? (i[7:0] ^ 8'h5A) : 8'($urandom);
    endtask

    // One $4014 strobe and the resulting transfer; the expected halt length and
    // bus trace come from the page contents and the get/put cycle rule.
    task automatic dma(input logic [7:0] pg, input int extra, input int inject_idx,
                       input int abort_idx);
        int unsigned strobe_cyc;
        int          n;
        int          k;
        int          n_exp;
        bit          align;
        bit          aborted;
        @(negedge clk);
        i_cs_n = 1'b0; i_rw = 1'b0; i_data = pg;
        strobe_cyc = cyc;
        rdy_low = 0;
        rd_addr.delete(); rd_cyc.delete();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        n = 0; k = 0; aborted = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!(o_bus_en && !o_rw)) chk("data_zero", {24'h0, o_data}, 32'h0);
            if (abort_idx >= 0 && o_bus_en && !o_rw && o_debug_index == abort_idx[7:0]) begin
                i_reset = 1'b1;
                aborted = 1'b1;
                break;
            end
            i_cs_n = 1'b1; i_data = 8'($urandom);
            i_rw = (k < extra) ? 1'b0 : 1'b1;
            k++;
            if (inject_idx >= 0 && o_bus_en && o_rw && o_debug_index == inject_idx[7:0]) begin
                i_cs_n = 1'b0; i_rw = 1'b0; i_data = 8'h07;
            end
        end while (o_busy && n < 3000);

        if (aborted) begin
            @(negedge clk);
            chk("abort_rdy",    {31'h0, o_rdy}, 32'h1);
            chk("abort_bus_en", {31'h0, o_bus_en}, 32'h0);
            chk("abort_rw",     {31'h0, o_rw}, 32'h1);
            chk("abort_busy",   {31'h0, o_busy}, 32'h0);
            chk("abort_index",  {24'h0, o_debug_index}, 32'h0);
            n_exp = abort_idx + 1;
            chk("abort_writes", wr_addr.size(), n_exp);
            for (int i = 0; i < wr_data.size() && i < n_exp; i++)
                chk("abort_wdata", {24'h0, wr_data[i]}, {24'h0, mem[{pg, i[7:0]}]});
            i_reset = 1'b0;
            i_cs_n = 1'b1; i_rw = 1'b1;
            return;
        end

        chk("timeout", {31'h0, o_busy}, 32'h0);
        chk("done_rdy", {31'h0, o_rdy}, 32'h1);
        align = ((strobe_cyc + 1 + extra) % 2) == 0;
        chk("rdy_low_len", rdy_low, 1 + extra + int'(align) + 512);
        chk("n_reads", rd_addr.size(), 256);
        chk("n_writes", wr_addr.size(), 256);
        if (rd_cyc.size() > 0)
            chk("first_read_cyc", rd_cyc[0], strobe_cyc + 2 + extra + int'(align));
        chk("page_latched", {24'h0, o_debug_page}, {24'h0, pg});
        for (int i = 0; i < 256 && i < rd_addr.size(); i++) begin
            chk("rd_addr", {16'h0, rd_addr[i]}, {16'h0, pg, i[7:0]});
            chk("rd_even", rd_cyc[i] % 2, 0);
        end
        for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
            chk("wr_addr", {16'h0, wr_addr[i]}, 32'h2004);
            chk("wr_data", {24'h0, wr_data[i]}, {24'h0, mem[{pg, i[7:0]}]});
            chk("wr_odd", wr_cyc[i] % 2, 1);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        i_reset = 1'b1; i_cs_n = 1'b1; i_rw = 1'b1; i_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy",     {31'h0, o_rdy}, 32'h1);
        chk("rst_bus_en",  {31'h0, o_bus_en}, 32'h0);
        chk("rst_rw",      {31'h0, o_rw}, 32'h1);
        chk("rst_busy",    {31'h0, o_busy}, 32'h0);
        chk("rst_address", {16'h0, o_address}, 32'h0);
        chk("rst_data",    {24'h0, o_data}, 32'h0);
        chk("rst_index",   {24'h0, o_debug_index}, 32'h0);
        chk("rst_page",    {24'h0, o_debug_page}, 32'h0);
        i_reset = 1'b0;

        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("idle_outputs", {29'h0, o_rdy, o_bus_en, o_busy}, 32'h4);
        end

        // Strobe on both parities with the 5A pattern page.
        fill_page(8'h02, 1'b1);
        while (cyc % 2 != 1) @(negedge clk);
        dma(8'h02, 0, -1, -1);
        while (cyc % 2 != 0) @(negedge clk);
        dma(8'h02, 0, -1, -1);

        // CPU write cycles stretch HALT.
        dma(8'h02, 2, -1, -1);

        // Second strobe mid-transfer must be ignored.
        dma(8'h02, 0, 40, -1);

        // Reset during the WRITE of byte $80, then a fresh copy from page 3.
        dma(8'h02, 0, -1, 8'h80);
        fill_page(8'h03, 1'b0);
        dma(8'h03, 0, -1, -1);

        for (int r = 0; r < 4; r++) begin
            logic [7:0] pg;
            pg = 8'($urandom);
            fill_page(pg, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            dma(pg, $urandom_range(0, 2), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
